// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sequencer and the DDS core.
package dds_pkg;

  localparam int DDS_WIDTH   = 10;
  localparam int DDS_MAX_AMP = 8;
  localparam int DDS_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } dds_ctrl_state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// Sweep stepper: dwell timer, widened frequency adder and end-of-sweep compare.
module dds_sweep_step #(
  parameter int FREQ_W  = 5,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  freq,
  output logic               step_tick,
  output logic               step_last,
  output logic [FREQ_W-1:0]  freq_next
);

  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] cnt_next;
  logic [DWELL_W-1:0] reload_reg;
  logic [DWELL_W-1:0] reload_next;
  logic [FREQ_W-1:0]  step_reg;
  logic [FREQ_W-1:0]  stop_reg;
  logic [FREQ_W:0]    sum;

  // A dwell of 0 behaves like 1: the counter reloads to 0 and ticks every cycle.
  always_comb begin
    reload_next = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    cnt_next    = (cnt_reg == '0) ? reload_reg : cnt_reg - DWELL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_reg    <= '0;
      reload_reg <= '0;
      step_reg   <= '0;
      stop_reg   <= '0;
    end else if (load) begin
      cnt_reg    <= reload_next;
      reload_reg <= reload_next;
      step_reg   <= f_step;
      stop_reg   <= f_stop;
    end else if (run) begin
      cnt_reg    <= cnt_next;
    end
  end

  // One extra bit so the next value never wraps below f_stop.
  assign sum       = {1'b0, freq} + {1'b0, step_reg};
  assign step_tick = run && (cnt_reg == '0);
  assign step_last = (step_reg != '0) && (sum > {1'b0, stop_reg});
  assign freq_next = sum[FREQ_W-1:0];

endmodule

// File: rtl/dds_ctrl.sv
// DDS sequencer: waveform table load, frequency sweeps, amplitude register and DDS reset.
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int WIDTH   = DDS_WIDTH,
  parameter int MAX_AMP = DDS_MAX_AMP,
  parameter int FREQ_W  = WIDTH / 2,
  parameter int DWELL_W = DDS_DWELL_W
) (
  input  logic               clk,
  input  logic               res,
  input  logic               cmd_load,
  input  logic               ld_valid,
  input  logic [MAX_AMP-1:0] ld_data,
  output logic               ld_ready,
  input  logic               sweep_start,
  input  logic               sweep_repeat,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               amp_wr,
  input  logic [MAX_AMP-1:0] amp_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               dds_res_n,
  output logic               dds_ram_wr,
  output logic [WIDTH-1:0]   dds_ram_addr,
  output logic [MAX_AMP-1:0] dds_ram_data,
  output logic [FREQ_W-1:0]  dds_freq,
  output logic [MAX_AMP-1:0] dds_amp
);

  dds_ctrl_state_t    state_reg, state_next;
  logic [WIDTH-1:0]   addr_reg, addr_next;
  logic [FREQ_W-1:0]  start_reg, start_next;
  logic               repeat_reg, repeat_next;
  logic               ld_ready_reg, ld_ready_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               res_n_reg, res_n_next;
  logic               ram_wr_reg, ram_wr_next;
  logic [WIDTH-1:0]   ram_addr_reg, ram_addr_next;
  logic [MAX_AMP-1:0] ram_data_reg, ram_data_next;
  logic [FREQ_W-1:0]  freq_reg, freq_next;
  logic [MAX_AMP-1:0] amp_reg, amp_next;

  logic               sweep_go;
  logic               step_tick;
  logic               step_last;
  logic [FREQ_W-1:0]  step_freq;

  dds_sweep_step #(
    .FREQ_W  (FREQ_W),
    .DWELL_W (DWELL_W)
  ) u_step (
    .clk       (clk),
    .res       (res),
    .load      (sweep_go),
    .run       (state_reg == SWEEP),
    .dwell     (dwell),
    .f_step    (f_step),
    .f_stop    (f_stop),
    .freq      (freq_reg),
    .step_tick (step_tick),
    .step_last (step_last),
    .freq_next (step_freq)
  );

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    start_next    = start_reg;
    repeat_next   = repeat_reg;
    ld_ready_next = ld_ready_reg;
    done_next     = 1'b0;
    res_n_next    = res_n_reg;
    ram_wr_next   = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    freq_next     = freq_reg;
    amp_next      = amp_wr ? amp_in : amp_reg;
    sweep_go      = 1'b0;

    if (abort) begin
      state_next    = IDLE;
      ld_ready_next = 1'b0;
      res_n_next    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          res_n_next = 1'b1;
          if (cmd_load) begin
            state_next    = LOAD;
            ld_ready_next = 1'b1;
            res_n_next    = 1'b0;
            addr_next     = '0;
          end else if (sweep_start) begin
            sweep_go    = 1'b1;
            state_next  = SWEEP;
            freq_next   = f_start;
            start_next  = f_start;
            repeat_next = sweep_repeat;
          end
        end
        LOAD: begin
          // ld_ready low inside LOAD marks the closing cycle after the last write.
          if (ld_ready_reg) begin
            if (ld_valid) begin
              ram_wr_next   = 1'b1;
              ram_addr_next = addr_reg;
              ram_data_next = ld_data;
              addr_next     = addr_reg + WIDTH'(1);
              if (addr_reg == {WIDTH{1'b1}}) begin
                ld_ready_next = 1'b0;
              end
            end
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
            res_n_next = 1'b1;
          end
        end
        SWEEP: begin
          if (step_tick) begin
            if (!step_last) begin
              freq_next = step_freq;
            end else if (repeat_reg) begin
              freq_next = start_reg;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      start_reg    <= '0;
      repeat_reg   <= 1'b0;
      ld_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      res_n_reg    <= 1'b0;
      ram_wr_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      freq_reg     <= '0;
      amp_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      start_reg    <= start_next;
      repeat_reg   <= repeat_next;
      ld_ready_reg <= ld_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      res_n_reg    <= res_n_next;
      ram_wr_reg   <= ram_wr_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
      freq_reg     <= freq_next;
      amp_reg      <= amp_next;
    end
  end

  assign ld_ready     = ld_ready_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign dds_res_n    = res_n_reg;
  assign dds_ram_wr   = ram_wr_reg;
  assign dds_ram_addr = ram_addr_reg;
  assign dds_ram_data = ram_data_reg;
  assign dds_freq     = freq_reg;
  assign dds_amp      = amp_reg;

endmodule

// File: tb/tb_dds_ctrl.sv
// Self-checking bench for dds_ctrl: table-driven and random sweeps against a sequence model, plus load/abort/reset sequences.
module tb_dds_ctrl;

  localparam int WIDTH   = 10;
  localparam int MAX_AMP = 8;
  localparam int FREQ_W  = 5;
  localparam int DWELL_W = 16;
  localparam int DEPTH   = 1 << WIDTH;

  logic               clk = 1'b0;
  logic               res = 1'b1;
  logic               cmd_load = 1'b0;
  logic               ld_valid = 1'b0;
  logic [MAX_AMP-1:0] ld_data = '0;
  logic               sweep_start = 1'b0;
  logic               sweep_repeat = 1'b0;
  logic [FREQ_W-1:0]  f_start = '0;
  logic [FREQ_W-1:0]  f_stop = '0;
  logic [FREQ_W-1:0]  f_step = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               amp_wr = 1'b0;
  logic [MAX_AMP-1:0] amp_in = '0;
  logic               abort = 1'b0;
  logic               ld_ready, busy, done, dds_res_n, dds_ram_wr;
  logic [WIDTH-1:0]   dds_ram_addr;
  logic [MAX_AMP-1:0] dds_ram_data, dds_amp;
  logic [FREQ_W-1:0]  dds_freq;

  dds_ctrl #(
    .WIDTH(WIDTH), .MAX_AMP(MAX_AMP), .FREQ_W(FREQ_W), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .res(res), .cmd_load(cmd_load), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .sweep_start(sweep_start), .sweep_repeat(sweep_repeat),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .amp_wr(amp_wr), .amp_in(amp_in), .abort(abort), .busy(busy), .done(done),
    .dds_res_n(dds_res_n), .dds_ram_wr(dds_ram_wr), .dds_ram_addr(dds_ram_addr),
    .dds_ram_data(dds_ram_data), .dds_freq(dds_freq), .dds_amp(dds_amp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    int start;
    int stop;
    int step;
    int dw;
    int exp_last;
    int exp_nvals;
  } sweep_vec_t;

  sweep_vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle frequency the sweep should show, derived from the sweep rules.
  function automatic void sweep_model(input int s, input int e, input int st, input int d);
    int v;
    int hold;
    exp_q.delete();
    hold = (d < 1) ? 1 : d;
    v = s;
    forever begin
      for (int k = 0; k < hold; k++) exp_q.push_back(v);
      if (st == 0 || v + st > e) break;
      v = v + st;
    end
  endfunction

  task automatic start_sweep(input int s, input int e, input int st, input int d, input logic rep);
    f_start = FREQ_W'(s);
    f_stop = FREQ_W'(e);
    f_step = FREQ_W'(st);
    dwell = DWELL_W'(d);
    sweep_repeat = rep;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input int d,
                           input int exp_last, input int exp_nvals, input bit use_tbl);
    int bad;
    int nvals;
    int prev;
    sweep_model(s, e, st, d);
    start_sweep(s, e, st, d, 1'b0);
    bad = 0;
    nvals = 0;
    prev = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (int'(dds_freq) !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) bad++;
      if (int'(dds_freq) != prev) begin
        nvals++;
        prev = int'(dds_freq);
      end
      tick();
    end
    check("sweep_seq", bad, 0);
    check("sweep_end_done_busy", int'({done, busy}), 2);
    check("sweep_hold_last", int'(dds_freq), exp_q[exp_q.size()-1]);
    if (use_tbl) begin
      check("sweep_last_tbl", int'(dds_freq), exp_last);
      check("sweep_nvals_tbl", nvals, exp_nvals);
    end
    tick();
    check("sweep_done_single", int'(done), 0);
    $display("sweep start=%0d stop=%0d step=%0d dwell=%0d cycles=%0d values=%0d", s, e, st, d,
             exp_q.size(), nvals);
  endtask

  initial begin
    int bad;
    int writes;
    int beats;
    int p;
    int mem[DEPTH];

    vecs[0] = '{2, 11, 3, 4, 11, 4};
    vecs[1] = '{20, 10, 5, 0, 20, 1};
    vecs[2] = '{0, 31, 31, 1, 31, 2};
    vecs[3] = '{3, 30, 4, 2, 27, 7};
    vecs[4] = '{5, 5, 1, 3, 5, 1};
    vecs[5] = '{1, 31, 15, 1, 31, 3};
    vecs[6] = '{30, 31, 3, 0, 30, 1};

    // Reset state
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ld_ready", int'(ld_ready), 0);
    check("rst_res_n", int'(dds_res_n), 0);
    check("rst_ram_wr", int'(dds_ram_wr), 0);
    check("rst_ram_addr", int'(dds_ram_addr), 0);
    check("rst_ram_data", int'(dds_ram_data), 0);
    check("rst_freq", int'(dds_freq), 0);
    check("rst_amp", int'(dds_amp), 0);
    res = 1'b0;
    tick();
    check("res_n_after_release", int'(dds_res_n), 1);
    $display("reset released");

    // Full load, valid held high, data = address[7:0]
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    check("load_entry", int'({busy, ld_ready, dds_res_n, dds_ram_wr}), 4'b1100);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = -1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data = MAX_AMP'(i);
      tick();
      if (dds_ram_wr !== 1'b1 || int'(dds_ram_addr) !== i || dds_res_n !== 1'b0 ||
          busy !== 1'b1 || done !== 1'b0) bad++;
      if (dds_ram_wr === 1'b1) mem[dds_ram_addr] = int'(dds_ram_data);
    end
    ld_valid = 1'b0;
    check("full_load_writes", bad, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != (i & 8'hFF)) bad++;
    check("full_load_table", bad, 0);
    tick();
    check("full_load_done", int'({done, busy, dds_res_n, dds_ram_wr, ld_ready}), 5'b10100);
    tick();
    check("full_load_done_single", int'(done), 0);
    $display("load full beats=%0d", DEPTH);

    // Load with toggling valid, abort after 300 beats
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    beats = 0;
    writes = 0;
    bad = 0;
    for (int c = 0; c < 2000 && beats < 300; c++) begin
      ld_valid = c[0];
      ld_data = MAX_AMP'($urandom);
      tick();
      if (dds_ram_wr === 1'b1) begin
        writes++;
        if (int'(dds_ram_addr) !== beats || dds_ram_data !== ld_data) bad++;
      end
      if (ld_valid) beats++;
      if (int'(dds_ram_wr) !== int'(ld_valid) || done !== 1'b0 || ld_ready !== 1'b1) bad++;
    end
    ld_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ld_valid = 1'b0;
    check("partial_load_beats", bad, 0);
    check("abort_load_outputs", int'({busy, done, dds_ram_wr, ld_ready, dds_res_n}), 5'b00001);
    for (int c = 0; c < 5; c++) begin
      if (dds_ram_wr === 1'b1) writes++;
      if (done === 1'b1) bad++;
      tick();
    end
    check("abort_load_write_count", writes, 300);
    check("abort_load_no_done", bad, 0);
    $display("load partial writes=%0d then abort", writes);

    // Table-driven sweeps
    for (int v = 0; v < 7; v++) begin
      run_sweep(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].dw,
                vecs[v].exp_last, vecs[v].exp_nvals, 1'b1);
    end

    // Random sweeps against the model
    for (int r = 0; r < 20; r++) begin
      run_sweep(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(1, 31)), int'($urandom_range(0, 5)), 0, 0, 1'b0);
    end

    // Repeating sweep, amplitude write mid-sweep, then abort
    sweep_model(2, 11, 3, 4);
    p = exp_q.size();
    start_sweep(2, 11, 3, 4, 1'b1);
    bad = 0;
    for (int i = 0; i < 3 * p; i++) begin
      if (int'(dds_freq) !== exp_q[i % p] || busy !== 1'b1 || done !== 1'b0) bad++;
      amp_wr = (i == 6);
      amp_in = 8'hA5;
      tick();
      if (i == 6) check("amp_wr_next_cycle", int'(dds_amp), 8'hA5);
    end
    amp_wr = 1'b0;
    check("repeat_sweep_seq", bad, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("repeat_abort_busy_done", int'({busy, done, dds_res_n}), 3'b001);
    check("repeat_abort_freq_held", int'(dds_freq), exp_q[(3 * p) % p]);
    $display("sweep repeat cycles=%0d then abort", 3 * p);

    // Zero step holds f_start until abort
    start_sweep(7, 20, 0, 2, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (int'(dds_freq) !== 7 || busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    check("zero_step_hold", bad, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("zero_step_abort", int'({busy, done, dds_freq}), 7);
    $display("sweep zero step held 40 cycles");

    // Simultaneous load and sweep commands
    f_start = 5'd9;
    cmd_load = 1'b1;
    sweep_start = 1'b1;
    tick();
    cmd_load = 1'b0;
    sweep_start = 1'b0;
    check("load_wins", int'({busy, ld_ready, dds_res_n}), 3'b110);
    check("load_wins_freq", int'(dds_freq), 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("load and sweep together -> load");

    // Reset in the middle of a load
    amp_wr = 1'b1;
    amp_in = 8'h3C;
    cmd_load = 1'b1;
    tick();
    amp_wr = 1'b0;
    cmd_load = 1'b0;
    ld_valid = 1'b1;
    repeat (5) tick();
    res = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("midload_rst_ctrl", int'({busy, done, ld_ready, dds_res_n, dds_ram_wr}), 0);
    check("midload_rst_data", int'({dds_ram_addr, dds_ram_data, dds_freq, dds_amp}), 0);
    res = 1'b0;
    tick();
    check("midload_rst_release", int'({busy, dds_res_n}), 1);
    $display("reset mid-load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
